slave_port: RTL
===============

SLAVE_PORT -- requirements
Module: slave_port

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 12, memory word-address width.
REQ-002 SHALL have parameter DATA_LEN, default 8, data word width.
REQ-003 SHALL have parameter BURST_LEN, default 12, burst-count field width; SHALL equal ADDR_LEN.
REQ-004 SHALL have port clk  in  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port slave_delay  in  6  number of wait cycles before each data beat.
REQ-007 SHALL have port master_valid  in  1  master driving a valid serial bit this cycle.
REQ-008 SHALL have port master_ready  in  1  master accepting a read-data bit this cycle.
REQ-009 SHALL have port write_en  in  1  write transaction, sampled on the first address beat.
REQ-010 SHALL have port read_en  in  1  read transaction, sampled on the first address beat.
REQ-011 SHALL have port rx_address  in  1  serial address bit, LSB first.
REQ-012 SHALL have port rx_burst  in  1  serial burst-count bit, LSB first, concurrent with address.
REQ-013 SHALL have port rx_data  in  1  serial write-data bit, LSB first.
REQ-014 SHALL have port tx_data  out  1  serial read-data bit, LSB first.
REQ-015 SHALL have port slave_ready  out  1  slave able to accept address or write data.
REQ-016 SHALL have port slave_valid  out  1  tx_data carries a valid read bit.
REQ-017 SHALL have ports mem_addr out ADDR_LEN, mem_wdata out DATA_LEN, mem_wen out 1, mem_ren out 1: local RAM access.
REQ-018 SHALL have port mem_rdata  in  DATA_LEN  RAM read data, valid exactly 1 cycle after mem_ren.

Function
REQ-019 SHALL implement states IDLE, ADDR, DELAY, WDATA, WMEM, RFETCH, RDATA.
REQ-020 IDLE: slave_ready=1; master_valid=1 SHALL capture bit 0 of address/burst, latch write_en/read_en, go to ADDR.
REQ-021 ADDR: each cycle with master_valid=1 SHALL shift one address and one burst bit; master_valid=0 SHALL pause the shift with no state change.
REQ-022 After ADDR_LEN bits, SHALL go to DELAY if write or read latched, else to IDLE with no RAM access.
REQ-023 write_en and read_en both latched SHALL be treated as a write.
REQ-024 Beat count SHALL equal the burst field value; value 0 SHALL mean 1 beat.
REQ-025 DELAY: slave_ready=0, slave_valid=0 for exactly slave_delay cycles (0 = skip), then WDATA (write) or RFETCH (read).
REQ-026 WDATA: slave_ready=1; each cycle with master_valid=1 SHALL shift one rx_data bit; after DATA_LEN bits go to WMEM.
REQ-027 WMEM: mem_wen=1 for one cycle with mem_addr=base+beat and the assembled word; slave_ready=0.
REQ-028 RFETCH: mem_ren=1 for one cycle with mem_addr=base+beat; the next cycle SHALL load mem_rdata into the shift register and enter RDATA.
REQ-029 RDATA: slave_valid=1, tx_data=current LSB; the register SHALL advance only on cycles with master_ready=1, and tx_data SHALL hold otherwise; after DATA_LEN accepted bits the beat ends.
REQ-030 After each beat: the beat counter SHALL increment; if beats remain go to DELAY, else go to IDLE.
REQ-031 Address arithmetic SHALL be modulo 2^ADDR_LEN; base 0xFFF with 2 beats SHALL access 0xFFF then 0x000.
REQ-032 slave_delay SHALL be sampled at the start of each DELAY entry; a change mid-delay SHALL not affect the running count.
REQ-033 mem_wen and mem_ren SHALL never be asserted in the same cycle and SHALL be 0 outside WMEM/RFETCH.

Reset
REQ-034 rst=0 SHALL immediately force IDLE and clear all shift registers and counters, including mid-transaction.
REQ-035 Reset values: slave_ready=1, slave_valid=0, tx_data=0, mem_wen=0, mem_ren=0, mem_addr=0, mem_wdata=0.

Structure
REQ-036 The state encoding and default widths (ADDR_LEN, DATA_LEN, BURST_LEN) SHALL live in the shared bus package.
REQ-037 One sub-module, serial_shift (parameterised width, load, shift-enable, serial in/out), SHALL be used for the address, burst and data registers.

Verification
REQ-038 Stimulus: write, addr 0x005, burst 1, data 0xA5, delay 0. Required response: mem_wen pulse with addr 0x005 and data 0xA5; back in IDLE.
REQ-039 Stimulus: RAM[0x010..0x012]=0x11,0x22,0x33; read, burst 3, delay 2, master_ready=1. Required response: serial 0x11,0x22,0x33 with 2 slave_ready=0 cycles before each beat.
REQ-040 Stimulus: read with master_ready toggling 1/0 each cycle. Required response: tx_data held on 0 cycles; 8 bits delivered in 16 cycles; word intact.
REQ-041 Stimulus: write, base 0xFFF, burst 2, data 0x01,0x02. Required response: writes to 0xFFF and 0x000.
REQ-042 Stimulus: assert rst=0 during the 4th write-data bit. Required response: outputs at reset values immediately, no mem_wen; the next transaction completes normally.
REQ-043 Stimulus: read_en=write_en=0 on the first address beat, 12 address bits sent. Required response: return to IDLE, no mem_wen/mem_ren.

Source files
------------

// File: rtl/slave_port_pkg.sv
// rtl/slave_port_pkg.sv - shared widths and state encoding for the serial slave port
//
// Purpose : default field widths and the controller state type used by
//           slave_port and its test environment.
// Contents: ADDR_LEN_DEF, DATA_LEN_DEF, BURST_LEN_DEF, DELAY_W, state_e.
package slave_port_pkg;

   localparam int ADDR_LEN_DEF  = 12;
   localparam int DATA_LEN_DEF  = 8;
   localparam int BURST_LEN_DEF = 12;
   localparam int DELAY_W       = 6;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_DELAY  = 3'd2,
      ST_WDATA  = 3'd3,
      ST_WMEM   = 3'd4,
      ST_RFETCH = 3'd5,
      ST_RDATA  = 3'd6
   } state_e;

endpackage

// File: rtl/slave_port_shift.sv
// rtl/slave_port_shift.sv - LSB-first serial shift register with parallel load
//
// Purpose : serial_shift holds one serial field. Bits enter at the MSB and
//           move toward bit 0, so after WIDTH shifts the first bit received
//           sits in bit 0. The same right shift presents read data LSB first.
// Ports   : clk_i, rst_ni      clock, asynchronous active-low clear
//           load_i, load_data_i parallel load (wins over shift)
//           shift_en_i, serial_i shift one bit in at the MSB
//           data_o              register contents
//           serial_o            current LSB
module serial_shift #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             shift_en_i,
   input  logic             serial_i,
   output logic [WIDTH-1:0] data_o,
   output logic             serial_o
);

   logic [WIDTH-1:0] data_q, data_d;

   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = load_data_i;
      end else if (shift_en_i) begin
         data_d = {serial_i, data_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o   = data_q;
   assign serial_o = data_q[0];

endmodule

// File: rtl/slave_port.sv
// rtl/slave_port.sv - bit-serial slave that bursts writes/reads into a local RAM
//
// Purpose : receives a serial address + burst count, then moves burst data
//           words between the serial link and a synchronous RAM, with a
//           programmable wait before every data beat.
// Ports   : clk, rst                  clock, asynchronous active-low reset
//           slave_delay              wait cycles before each beat
//           master_valid/master_ready serial handshakes from the master
//           write_en/read_en         transaction type (first address beat)
//           rx_address/rx_burst/rx_data serial inputs, LSB first
//           tx_data/slave_valid/slave_ready serial read data and flow control
//           mem_addr/mem_wdata/mem_wen/mem_ren/mem_rdata RAM port
module slave_port
   import slave_port_pkg::*;
#(
   parameter int ADDR_LEN  = ADDR_LEN_DEF,
   parameter int DATA_LEN  = DATA_LEN_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DELAY_W-1:0]  slave_delay,
   input  logic                master_valid,
   input  logic                master_ready,
   input  logic                write_en,
   input  logic                read_en,
   input  logic                rx_address,
   input  logic                rx_burst,
   input  logic                rx_data,
   output logic                tx_data,
   output logic                slave_ready,
   output logic                slave_valid,
   output logic [ADDR_LEN-1:0] mem_addr,
   output logic [DATA_LEN-1:0] mem_wdata,
   output logic                mem_wen,
   output logic                mem_ren,
   input  logic [DATA_LEN-1:0] mem_rdata
);

   localparam int MAXLEN = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
   localparam int CNT_W  = $clog2(MAXLEN + 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DELAY_W-1:0]   dly_q, dly_d;
   logic [BURST_LEN-1:0] beat_q, beat_d;
   logic                 wr_q, wr_d, rd_q, rd_d;
   logic                 fetch_wait_q, fetch_wait_d;
   logic                 slave_ready_q, slave_valid_q, mem_wen_q, mem_ren_q;

   logic                 addr_shift, data_shift, data_load, data_in;
   logic                 go_delay, end_beat, last_beat;
   state_e               post_delay;
   logic [ADDR_LEN-1:0]  addr_q;
   logic [BURST_LEN-1:0] burst_q, beats_m1;
   logic [DATA_LEN-1:0]  data_q;
   logic                 data_lsb, addr_unused_lsb, burst_unused_lsb;

   serial_shift #(.WIDTH(ADDR_LEN)) u_addr_sr (
      .clk_i(clk), .rst_ni(rst), .load_i(1'b0), .load_data_i('0),
      .shift_en_i(addr_shift), .serial_i(rx_address),
      .data_o(addr_q), .serial_o(addr_unused_lsb)
   );

   serial_shift #(.WIDTH(BURST_LEN)) u_burst_sr (
      .clk_i(clk), .rst_ni(rst), .load_i(1'b0), .load_data_i('0),
      .shift_en_i(addr_shift), .serial_i(rx_burst),
      .data_o(burst_q), .serial_o(burst_unused_lsb)
   );

   serial_shift #(.WIDTH(DATA_LEN)) u_data_sr (
      .clk_i(clk), .rst_ni(rst), .load_i(data_load), .load_data_i(mem_rdata),
      .shift_en_i(data_shift), .serial_i(data_in),
      .data_o(data_q), .serial_o(data_lsb)
   );

   // A burst field of 0 still moves one word.
   assign beats_m1   = (burst_q == '0) ? '0 : burst_q - BURST_LEN'(1);
   assign last_beat  = (beat_q == beats_m1);
   // A write wins when both enables were latched.
   assign post_delay = wr_q ? ST_WDATA : ST_RFETCH;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      dly_d        = dly_q;
      beat_d       = beat_q;
      wr_d         = wr_q;
      rd_d         = rd_q;
      fetch_wait_d = 1'b0;
      addr_shift   = 1'b0;
      data_shift   = 1'b0;
      data_load    = 1'b0;
      data_in      = 1'b0;
      go_delay     = 1'b0;
      end_beat     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (master_valid) begin
               addr_shift = 1'b1;
               wr_d       = write_en;
               rd_d       = read_en;
               cnt_d      = CNT_W'(1);
               beat_d     = '0;
               state_d    = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (master_valid) begin
               addr_shift = 1'b1;
               if (cnt_q == CNT_W'(ADDR_LEN - 1)) begin
                  if (wr_q || rd_q) go_delay = 1'b1;
                  else              state_d  = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DELAY: begin
            if (dly_q <= DELAY_W'(1)) state_d = post_delay;
            else                      dly_d   = dly_q - DELAY_W'(1);
         end
         ST_WDATA: begin
            if (master_valid) begin
               data_shift = 1'b1;
               data_in    = rx_data;
               if (cnt_q == CNT_W'(DATA_LEN - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_WMEM;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_WMEM: end_beat = 1'b1;
         ST_RFETCH: begin
            // First cycle issues the read; the second catches the RAM's
            // registered data one cycle later.
            if (!fetch_wait_q) begin
               fetch_wait_d = 1'b1;
            end else begin
               data_load = 1'b1;
               cnt_d     = '0;
               state_d   = ST_RDATA;
            end
         end
         ST_RDATA: begin
            if (master_ready) begin
               data_shift = 1'b1;
               if (cnt_q == CNT_W'(DATA_LEN - 1)) end_beat = 1'b1;
               else                               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (end_beat) begin
         beat_d = beat_q + BURST_LEN'(1);
         cnt_d  = '0;
         if (last_beat) state_d  = ST_IDLE;
         else           go_delay = 1'b1;
      end

      // slave_delay is captured only here, so later changes cannot stretch
      // or shorten a wait already running.
      if (go_delay) begin
         cnt_d = '0;
         if (slave_delay == '0) begin
            state_d = post_delay;
         end else begin
            dly_d   = slave_delay;
            state_d = ST_DELAY;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         dly_q         <= '0;
         beat_q        <= '0;
         wr_q          <= 1'b0;
         rd_q          <= 1'b0;
         fetch_wait_q  <= 1'b0;
         slave_ready_q <= 1'b1;
         slave_valid_q <= 1'b0;
         mem_wen_q     <= 1'b0;
         mem_ren_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         dly_q         <= dly_d;
         beat_q        <= beat_d;
         wr_q          <= wr_d;
         rd_q          <= rd_d;
         fetch_wait_q  <= fetch_wait_d;
         slave_ready_q <= (state_d == ST_IDLE) || (state_d == ST_ADDR) ||
                          (state_d == ST_WDATA);
         slave_valid_q <= (state_d == ST_RDATA);
         mem_wen_q     <= (state_d == ST_WMEM);
         mem_ren_q     <= (state_d == ST_RFETCH) && !fetch_wait_d;
      end
   end

   assign slave_ready = slave_ready_q;
   assign slave_valid = slave_valid_q;
   assign mem_wen     = mem_wen_q;
   assign mem_ren     = mem_ren_q;
   assign tx_data     = slave_valid_q & data_lsb;
   // Address wraps naturally in ADDR_LEN bits.
   assign mem_addr    = (mem_wen_q || mem_ren_q) ? addr_q + ADDR_LEN'(beat_q) : '0;
   assign mem_wdata   = mem_wen_q ? data_q : '0;

endmodule
